// File: rtl/bcd_conv_arbiter_if.sv
// Request/grant/result bundle shared by the two requesters and the
// double-dabble converter.
interface bcd_conv_arbiter_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  req0;
  logic [WIDTH-1:0]      data0;
  logic                  gnt0;
  logic                  req1;
  logic [WIDTH-1:0]      data1;
  logic                  gnt1;
  logic                  busy;
  logic                  done;
  logic                  owner;
  logic [4*DIGITS-1:0]   bcd;

  modport master (
    output req0, data0, req1, data1,
    input  gnt0, gnt1, busy, done, owner, bcd
  );

  modport slave (
    input  req0, data0, req1, data1,
    output gnt0, gnt1, busy, done, owner, bcd
  );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Shared sequential binary-to-BCD converter (shift-add-3) with a two-way
// round-robin arbiter. Optional macro BCD_BLANK_EN enables leading-zero blanking.
module bcd_conv_arbiter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  bcd_conv_arbiter_if.slave   bus,
  output logic [1:0]          state_o
);
  // Handshake: a requester holds reqN and dataN stable until gntN is seen;
  // the operand is captured at the edge where gntN is high. gntN exists only
  // in IDLE. done pulses for one cycle with bcd/owner valid, and they hold
  // until the next done.
  localparam int BW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [BW-1:0]       scr_q, scr_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cur_q, cur_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic                gnt0, gnt1;
  logic [BW-1:0]       adj;
  logic [BW+WIDTH-1:0] shifted;

`ifdef BCD_BLANK_EN
  function automatic logic [BW-1:0] fmt(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          lead;
    r    = v;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (v[4*i +: 4] == 4'd0)) r[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
    return r;
  endfunction
`else
  function automatic logic [BW-1:0] fmt(input logic [BW-1:0] v);
    return v;
  endfunction
`endif

  // last_q == 1 means requester 1 was granted last, so requester 0 wins a tie.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == S_IDLE) begin
      if (bus.req0 && (!bus.req1 || last_q)) gnt0 = 1'b1;
      else if (bus.req1)                     gnt1 = 1'b1;
    end
  end

  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? scr_q[4*i +: 4] + 4'd3
                                                 : scr_q[4*i +: 4];
    end
    shifted = {adj, bin_q} << 1;
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (gnt0 || gnt1) begin
          bin_d   = gnt0 ? bus.data0 : bus.data1;
          scr_d   = '0;
          cnt_d   = '0;
          cur_d   = gnt1;
          last_d  = gnt1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        scr_d = shifted[BW+WIDTH-1:WIDTH];
        bin_d = shifted[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          bcd_d   = fmt(shifted[BW+WIDTH-1:WIDTH]);
          owner_d = cur_q;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      cur_q   <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign bus.gnt0  = gnt0;
  assign bus.gnt1  = gnt1;
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.done  = (state_q == S_DONE);
  assign bus.owner = owner_q;
  assign bus.bcd   = bcd_q;
  assign state_o   = state_q;
endmodule
